// File: rtl/frame_tx_arbiter_pkg.sv
// Shared definitions for the frame transmit arbiter.
//   - default channel count and sync byte
//   - FSM state encoding
//   - next_index(): round-robin pointer advance with wrap
package frame_tx_arbiter_pkg;

  localparam int         N_SRC_DEFAULT     = 20;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ADDR,
    ST_LEN,
    ST_RD,
    ST_WAIT,
    ST_PAY,
    ST_CSUM
  } state_t;

  // Index following k in a ring of n entries.
  function automatic int next_index(input int k, input int n);
    return (k == n - 1) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/frame_tx_arbiter_if.sv
// Channel-side and uart-side buses of the frame transmit arbiter.
//   have_msg_bus  channel i holds a complete reply
//   len_bus       channel i payload length, byte lane i
//   data_bus      channel i payload byte, byte lane i
//   rdreq_bus     one-cycle pop strobe to channel i
//   tx_data/tx_valid/tx_ready  AXI-stream byte output to the uart
// master = arbiter side, slave = channels + uart side.
interface frame_tx_arbiter_if
  import frame_tx_arbiter_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT
);
  logic [N_SRC-1:0]   have_msg_bus;
  logic [8*N_SRC-1:0] len_bus;
  logic [8*N_SRC-1:0] data_bus;
  logic [N_SRC-1:0]   rdreq_bus;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    input  have_msg_bus, len_bus, data_bus, tx_ready,
    output rdreq_bus, tx_data, tx_valid
  );

  modport slave (
    output have_msg_bus, len_bus, data_bus, tx_ready,
    input  rdreq_bus, tx_data, tx_valid
  );
endinterface

// File: rtl/frame_tx_arbiter_rr_arbiter.sv
// Combinational request arbiter.
//   req  pending requests
//   ptr  round-robin search start (ignored in fixed-priority mode)
//   gnt  one-hot winner, zero when no request
// RR_MODE=1: first set bit at or after ptr, wrapping. RR_MODE=0: lowest set bit.
module rr_arbiter
  import frame_tx_arbiter_pkg::*;
#(
  parameter int N       = N_SRC_DEFAULT,
  parameter int RR_MODE = 1,
  localparam int PW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  // NOTE: every variable written in a combinational block gets a default
  // first; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    int   start;
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    start = (RR_MODE != 0 && int'(ptr) < N) ? int'(ptr) : 0;
    for (int off = 0; off < N; off++) begin
      idx = start + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_tx_arbiter.sv
// Frame transmit arbiter: picks one pending reply channel, streams
// SYNC_BYTE, ADDR, LEN, payload[LEN], CSUM to the uart. CSUM is the XOR of
// ADDR, LEN and the payload bytes.
//   clk, rst  clock, asynchronous active-high reset
//   bus       channel buses and uart stream (master side)
//   busy      high from grant until the checksum byte is accepted
//   grant     one-hot owner of the current frame
// Each payload byte is fetched on demand: RD pulses rdreq, WAIT covers the
// channel read latency, PAY offers the byte.
module frame_tx_arbiter
  import frame_tx_arbiter_pkg::*;
#(
  parameter int         N_SRC     = N_SRC_DEFAULT,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         RR_MODE   = 1,
  parameter int         RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  frame_tx_arbiter_if.master bus,
  output logic               busy,
  output logic [N_SRC-1:0]   grant
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_t         state, state_nxt;
  logic [PW-1:0]  ptr;
  logic [7:0]     addr;
  logic [7:0]     rem;
  logic [7:0]     csum;
  logic [7:0]     pay_byte;
  logic [1:0]     wait_cnt;
  logic [N_SRC-1:0] arb_gnt;
  logic [7:0]     arb_addr;
  logic [7:0]     arb_len;
  logic [7:0]     data_sel;
  logic           tx_fire;
  logic           any_req;
  logic           wait_done;

  assign any_req   = |bus.have_msg_bus;
  assign tx_fire   = bus.tx_valid && bus.tx_ready;
  assign wait_done = (wait_cnt == 2'(RD_LAT - 1));

  rr_arbiter #(
    .N       (N_SRC),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req (bus.have_msg_bus),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // Winner's address and length, and the granted channel's data lane.
  always_comb begin
    arb_addr = '0;
    arb_len  = '0;
    data_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (arb_gnt[i]) begin
        arb_addr = 8'(i);
        arb_len  = bus.len_bus[8*i +: 8];
      end
      if (grant[i]) data_sel = bus.data_bus[8*i +: 8];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.rdreq_bus = '0;
    unique case (state)
      ST_IDLE: if (any_req) state_nxt = ST_SYNC;
      ST_SYNC: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = SYNC_BYTE;
        if (tx_fire) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = addr;
        if (tx_fire) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = rem;
        if (tx_fire) state_nxt = (rem == 8'd0) ? ST_CSUM : ST_RD;
      end
      ST_RD: begin
        bus.rdreq_bus = grant;
        state_nxt     = ST_WAIT;
      end
      ST_WAIT: if (wait_done) state_nxt = ST_PAY;
      ST_PAY: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = pay_byte;
        // rem still holds the pre-decrement count on the accepting cycle.
        if (tx_fire) state_nxt = (rem == 8'd1) ? ST_CSUM : ST_RD;
      end
      ST_CSUM: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = csum;
        if (tx_fire) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame context: latched at grant, updated as bytes are accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      addr     <= '0;
      rem      <= '0;
      csum     <= '0;
      pay_byte <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant <= arb_gnt;
            addr  <= arb_addr;
            rem   <= arb_len;
            csum  <= arb_addr ^ arb_len;
            busy  <= 1'b1;
            if (RR_MODE != 0) ptr <= PW'(next_index(int'(arb_addr), N_SRC));
          end
        end
        ST_RD: wait_cnt <= '0;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_done) pay_byte <= data_sel;
        end
        ST_PAY: begin
          if (tx_fire) begin
            csum <= csum ^ pay_byte;
            rem  <= rem - 8'd1;
          end
        end
        ST_CSUM: begin
          if (tx_fire) begin
            busy  <= 1'b0;
            grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_arbiter.sv
module tb_frame_tx_arbiter;
  import frame_tx_arbiter_pkg::*;

  localparam int         N      = 20;
  localparam int         RD_LAT = 1;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_tx_arbiter_if #(.N_SRC(N)) bus_a ();
  frame_tx_arbiter_if #(.N_SRC(N)) bus_b ();
  logic         busy_a, busy_b;
  logic [N-1:0] grant_a, grant_b;

  frame_tx_arbiter #(.N_SRC(N), .SYNC_BYTE(SYNC), .RR_MODE(1), .RD_LAT(RD_LAT)) u_dut_rr (
    .clk (clk), .rst (rst), .bus (bus_a), .busy (busy_a), .grant (grant_a)
  );
  frame_tx_arbiter #(.N_SRC(N), .SYNC_BYTE(SYNC), .RR_MODE(0), .RD_LAT(RD_LAT)) u_dut_fp (
    .clk (clk), .rst (rst), .bus (bus_b), .busy (busy_b), .grant (grant_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- channel model (round-robin instance) ----------------
  logic [7:0] ch_bytes [N][$];
  int         ch_msgs  [N][$];
  logic [N-1:0] pend_pop = '0;
  int ready_mode = 0;
  int ready_cnt  = 0;

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] m_data [N][$];
  int         m_len  [N][$];
  int         m_ptr = 0;
  logic [7:0] exp_byte [$];
  int         exp_chan [$];
  int         exp_flen [$];

  task automatic add_msg(input int ch, input int len, input logic [7:0] base, input bit rnd);
    m_len[ch].push_back(len);
    for (int j = 0; j < len; j++)
      m_data[ch].push_back(rnd ? 8'($urandom) : 8'(base * (j + 1)));
  endtask

  // Publish staged messages to the channels and derive the expected frame
  // order: every arbitration takes the first pending channel at or after the
  // pointer, then moves the pointer just past the winner.
  task automatic commit_round();
    int total;
    total = 0;
    for (int c = 0; c < N; c++) begin
      foreach (m_len[c][k]) ch_msgs[c].push_back(m_len[c][k]);
      foreach (m_data[c][k]) ch_bytes[c].push_back(m_data[c][k]);
      total += m_len[c].size();
    end
    while (total > 0) begin
      for (int off = 0; off < N; off++) begin
        int c;
        c = (m_ptr + off) % N;
        if (m_len[c].size() > 0) begin
          int L;
          logic [7:0] cs, b;
          L = m_len[c].pop_front();
          exp_chan.push_back(c);
          exp_flen.push_back(L);
          exp_byte.push_back(SYNC);
          exp_byte.push_back(8'(c));
          exp_byte.push_back(8'(L));
          cs = 8'(c) ^ 8'(L);
          for (int j = 0; j < L; j++) begin
            b = m_data[c].pop_front();
            exp_byte.push_back(b);
            cs = cs ^ b;
          end
          exp_byte.push_back(cs);
          m_ptr = (c + 1) % N;
          total--;
          break;
        end
      end
    end
  endtask

  // Channel/uart drivers, just after the active edge.
  always @(posedge clk) begin
    logic [N-1:0]   hv;
    logic [8*N-1:0] lv;
    logic [8*N-1:0] dv;
    #1;
    dv = bus_a.data_bus;
    for (int i = 0; i < N; i++) begin
      if (pend_pop[i] && ch_bytes[i].size() > 0) dv[8*i +: 8] = ch_bytes[i].pop_front();
      hv[i]        = (ch_msgs[i].size() > 0);
      lv[8*i +: 8] = hv[i] ? 8'(ch_msgs[i][0]) : 8'h00;
    end
    pend_pop = '0;
    bus_a.data_bus     = dv;
    bus_a.have_msg_bus = hv;
    bus_a.len_bus      = lv;
    ready_cnt++;
    case (ready_mode)
      0:       bus_a.tx_ready = 1'b1;
      1:       bus_a.tx_ready = (ready_cnt % 3 == 0);
      default: bus_a.tx_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- monitor (round-robin instance) ----------------
  int  cyc = 0;
  int  frame_pos = 0;
  int  cur_chan = 0;
  int  cur_flen = 0;
  int  pulses = 0;
  int  csum_cyc = 0;
  bit  gap_armed = 0;
  bit  gap_pending = 0;
  logic busy_q = 0;
  logic prev_valid = 0, prev_ready = 0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      frame_pos  = 0;
      busy_q     = 0;
      prev_valid = 0;
      pend_pop   = '0;
    end else begin
      if (busy_a && !busy_q) begin
        int g;
        g = oh_idx(grant_a);
        check("grant_has_msg", (g >= 0) ? ch_msgs[g].size() : 0, (g >= 0) ? 1 + ch_msgs[g].size() - 1 : 1);
        if (g >= 0 && ch_msgs[g].size() > 0) void'(ch_msgs[g].pop_front());
      end
      busy_q = busy_a;
      if (bus_a.rdreq_bus != '0) begin
        check("rdreq_target", 32'(bus_a.rdreq_bus), 32'(1) << cur_chan);
        check("rdreq_in_stall", 32'(bus_a.tx_valid && !bus_a.tx_ready), 0);
        pulses++;
        pend_pop = pend_pop | bus_a.rdreq_bus;
      end
      if (prev_valid && !prev_ready)
        check("stall_hold", {23'd0, bus_a.tx_valid, bus_a.tx_data}, {23'd0, 1'b1, prev_data});
      if (gap_armed && gap_pending && bus_a.tx_valid && frame_pos == 0) begin
        check("frame_gap", cyc - csum_cyc, 2);
        gap_pending = 0;
      end
      if (bus_a.tx_valid && bus_a.tx_ready) begin
        if (frame_pos == 0) begin
          check("frame_expected", exp_chan.size() > 0, 1);
          if (exp_chan.size() > 0) begin
            cur_chan = exp_chan.pop_front();
            cur_flen = exp_flen.pop_front();
          end
          pulses = 0;
        end
        if (exp_byte.size() == 0) check("byte_underflow", exp_byte.size(), 1);
        else check($sformatf("byte_ch%0d_pos%0d", cur_chan, frame_pos), bus_a.tx_data, exp_byte.pop_front());
        frame_pos++;
        if (frame_pos == cur_flen + 4) begin
          check("rdreq_count", pulses, cur_flen);
          frame_pos   = 0;
          csum_cyc    = cyc;
          gap_pending = 1;
        end
      end
      prev_valid = bus_a.tx_valid;
      prev_ready = bus_a.tx_ready;
      prev_data  = bus_a.tx_data;
    end
  end

  // ---------------- fixed-priority instance: driver + monitor ----------------
  bit  b_on = 0;
  int  b_pos = 0;
  int  b_win = 0;
  int  b_frames = 0;

  always @(negedge clk) begin
    if (rst || !b_on) begin
      b_pos = 0;
    end else begin
      if (bus_b.rdreq_bus != '0) check("fp_rdreq", 32'(bus_b.rdreq_bus), 32'(1) << b_win);
      if (bus_b.tx_valid && bus_b.tx_ready) begin
        logic [7:0] e;
        if (b_pos == 0) b_win = oh_idx(bus_b.have_msg_bus);  // lowest pending index
        case (b_pos)
          0:       e = SYNC;
          1:       e = 8'(b_win);
          2:       e = 8'd1;
          3:       e = 8'h30 + 8'(b_win);
          default: e = 8'(b_win) ^ 8'd1 ^ (8'h30 + 8'(b_win));
        endcase
        check($sformatf("fp_byte_pos%0d", b_pos), bus_b.tx_data, e);
        b_pos++;
        if (b_pos == 5) begin
          b_pos = 0;
          b_frames++;
        end
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 4000 && !done; k++) begin
      @(posedge clk); #2;
      done = (exp_byte.size() == 0) && !busy_a && (frame_pos == 0);
    end
    check("drain", done, 1);
    if (!done) begin
      exp_byte.delete(); exp_chan.delete(); exp_flen.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic clear_channels();
    for (int c = 0; c < N; c++) begin
      ch_bytes[c].delete(); ch_msgs[c].delete();
      m_data[c].delete();   m_len[c].delete();
    end
    exp_byte.delete(); exp_chan.delete(); exp_flen.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    bus_a.tx_ready = 1'b1;
    bus_a.have_msg_bus = '0; bus_a.len_bus = '0; bus_a.data_bus = '0;
    bus_b.tx_ready = 1'b1;
    bus_b.have_msg_bus = '0;
    for (int i = 0; i < N; i++) begin
      bus_b.len_bus[8*i +: 8]  = 8'd1;
      bus_b.data_bus[8*i +: 8] = 8'h30 + 8'(i);
    end
    repeat (3) @(posedge clk);
    #2;
    // Reset state
    check("rst_tx_valid", bus_a.tx_valid, 0);
    check("rst_tx_data", bus_a.tx_data, 0);
    check("rst_busy", busy_a, 0);
    check("rst_grant", grant_a, 0);
    check("rst_rdreq", bus_a.rdreq_bus, 0);
    check("rst_fp_valid", bus_b.tx_valid, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // ch3, len 2, bytes 11 22
    add_msg(3, 2, 8'h11, 0);
    commit_round();
    drain();

    // ch0, len 0: no payload, no rdreq
    add_msg(0, 0, 8'h00, 0);
    commit_round();
    drain();

    // Reset while LEN is on the bus
    add_msg(9, 3, 8'h21, 0);
    commit_round();
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      seen = bus_a.tx_valid && (frame_pos == 2);
    end
    check("reach_len_byte", seen, 1);
    rst = 1'b1;
    #1;
    check("midrst_tx_valid", bus_a.tx_valid, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_grant", grant_a, 0);
    check("midrst_tx_data", bus_a.tx_data, 0);
    clear_channels();
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("rdreq_after_rst", bus_a.rdreq_bus, 0);
      check("busy_after_rst", busy_a, 0);
    end

    // Round-robin with held requests on 0, 5, 19: order 0,5,19,0,5,19
    for (int r = 0; r < 2; r++) begin
      add_msg(0, 1, 8'h41, 0);
      add_msg(5, 1, 8'h45, 0);
      add_msg(19, 1, 8'h49, 0);
    end
    gap_pending = 0;
    gap_armed   = 1;
    commit_round();
    drain();
    gap_armed = 0;

    // ch7, len 4, tx_ready high one cycle in three
    ready_mode = 1;
    add_msg(7, 4, 8'h11, 0);
    commit_round();
    drain();
    ready_mode = 0;

    // Longest payload
    add_msg(12, 255, 8'h00, 1);
    commit_round();
    drain();

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      int nch;
      ready_mode = $urandom_range(0, 2);
      nch = $urandom_range(1, 5);
      for (int k = 0; k < nch; k++) begin
        int ch, nm;
        ch = $urandom_range(0, N - 1);
        nm = $urandom_range(1, 2);
        for (int m = 0; m < nm; m++) add_msg(ch, $urandom_range(0, 8), 8'h00, 1);
      end
      commit_round();
      drain();
    end
    ready_mode = 0;

    // Fixed priority, requests held on 0, 5, 19: only channel 0 is served
    b_on = 1;
    @(posedge clk); #1;
    bus_b.have_msg_bus = (N'(1) << 0) | (N'(1) << 5) | (N'(1) << 19);
    repeat (45) @(posedge clk);
    #1 bus_b.have_msg_bus = '0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk); #2;
      seen = !busy_b;
    end
    check("fp_idle", seen, 1);
    check("fp_frames_min4", b_frames >= 4, 1);
    b_on = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
